// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial pattern transmit path.
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_pkg

// File: rtl/serial_pattern_gen.sv
// Parallel-to-serial pattern transmitter with a one-entry holding buffer.
// Words arrive over valid/ready and leave one bit per clock with no inter-word gap.
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_pattern,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_shift_reg;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_hold_reg;
    logic [WIDTH-1:0] w_hold_nxt;
    logic             r_hold_valid;
    logic             w_hold_valid_nxt;
    logic             r_serial_pattern;
    logic             r_serial_valid;
    logic             r_word_done;
    logic             r_busy;
    logic             w_bit_nxt;
    logic             w_accept;
    logic             w_last;

    assign data_ready     = enable && !r_hold_valid;
    assign w_accept       = data_valid && data_ready;
    assign w_last         = (r_state == SHIFT) && (r_bit_cnt == LAST_CNT);
    assign serial_pattern = r_serial_pattern;
    assign serial_valid   = r_serial_valid;
    assign word_done      = r_word_done;
    assign busy           = r_busy;

    // Advance the shifter by one bit in the configured direction.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] res;
        if (LSB_FIRST) begin
            res = {1'b0, word[WIDTH-1:1]};
        end else begin
            res = {word[WIDTH-2:0], 1'b0};
        end
        return res;
    endfunction

    // Next-state logic: word sequencing, hold buffer and the enable flush.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift_reg;
        w_cnt_nxt        = r_bit_cnt;
        w_hold_nxt       = r_hold_reg;
        w_hold_valid_nxt = r_hold_valid;
        if (!enable) begin
            w_state_nxt      = IDLE;
            w_shift_nxt      = {WIDTH{1'b0}};
            w_cnt_nxt        = {CNT_W{1'b0}};
            w_hold_nxt       = {WIDTH{1'b0}};
            w_hold_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = SHIFT;
                        w_shift_nxt = data_in;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        // A held word always wins; data_ready is low then, so no accept can collide.
                        if (r_hold_valid) begin
                            w_shift_nxt      = r_hold_reg;
                            w_cnt_nxt        = {CNT_W{1'b0}};
                            w_hold_valid_nxt = 1'b0;
                        end else if (w_accept) begin
                            w_shift_nxt = data_in;
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end else begin
                            w_state_nxt = IDLE;
                            w_shift_nxt = {WIDTH{1'b0}};
                            w_cnt_nxt   = {CNT_W{1'b0}};
                        end
                    end else begin
                        w_shift_nxt = shift_once(r_shift_reg);
                        w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
                        if (w_accept) begin
                            w_hold_nxt       = data_in;
                            w_hold_valid_nxt = 1'b1;
                        end else begin
                            w_hold_valid_nxt = r_hold_valid;
                        end
                    end
                end
                default: begin
                    w_state_nxt      = IDLE;
                    w_shift_nxt      = {WIDTH{1'b0}};
                    w_cnt_nxt        = {CNT_W{1'b0}};
                    w_hold_nxt       = {WIDTH{1'b0}};
                    w_hold_valid_nxt = 1'b0;
                end
            endcase
        end
        if (w_state_nxt == SHIFT) begin
            w_bit_nxt = LSB_FIRST ? w_shift_nxt[0] : w_shift_nxt[WIDTH-1];
        end else begin
            w_bit_nxt = 1'b0;
        end
    end

    // State, datapath and registered line outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state          <= IDLE;
            r_shift_reg      <= {WIDTH{1'b0}};
            r_bit_cnt        <= {CNT_W{1'b0}};
            r_hold_reg       <= {WIDTH{1'b0}};
            r_hold_valid     <= 1'b0;
            r_serial_pattern <= 1'b0;
            r_serial_valid   <= 1'b0;
            r_word_done      <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_shift_reg      <= w_shift_nxt;
            r_bit_cnt        <= w_cnt_nxt;
            r_hold_reg       <= w_hold_nxt;
            r_hold_valid     <= w_hold_valid_nxt;
            r_serial_pattern <= w_bit_nxt;
            r_serial_valid   <= (w_state_nxt == SHIFT);
            r_word_done      <= (w_state_nxt == SHIFT) && (w_cnt_nxt == LAST_CNT);
            r_busy           <= (w_state_nxt == SHIFT) || w_hold_valid_nxt;
        end
    end

endmodule : serial_pattern_gen

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench: directed table and sequences plus random traffic vs. a word-level model.
module tb_serial_pattern_gen;

    localparam int W = 8;

    logic         clk;
    logic         rstb;
    logic         enable;
    logic [W-1:0] data_in;
    logic         data_valid;
    logic         m_ready, m_sp, m_sv, m_wd, m_busy;
    logic         l_ready, l_sp, l_sv, l_wd, l_busy;

    serial_pattern_gen #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rstb(rstb), .enable(enable), .data_in(data_in),
        .data_valid(data_valid), .data_ready(m_ready), .serial_pattern(m_sp),
        .serial_valid(m_sv), .word_done(m_wd), .busy(m_busy)
    );

    serial_pattern_gen #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rstb(rstb), .enable(enable), .data_in(data_in),
        .data_valid(data_valid), .data_ready(l_ready), .serial_pattern(l_sp),
        .serial_valid(l_sv), .word_done(l_wd), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Word-level reference: position of the bit on the line (-1 = idle) and a queue of waiting words.
    int           mod_pos;
    logic [W-1:0] mod_cur;
    logic [W-1:0] mod_held[$];

    logic h_sp[32], h_sv[32], h_wd[32], h_rdy[32], h_busy[32], h_lsp[32];

    typedef struct {
        logic         en;
        logic         v;
        logic [W-1:0] d;
        logic         sp;
        logic         sv;
        logic         wd;
        logic         rdy;
        logic         bsy;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mod_pos = -1;
        mod_cur = '0;
        mod_held.delete();
    endtask

    task automatic model_step(input logic en, input logic v, input logic [W-1:0] d);
        logic acc;
        if (!en) begin
            model_reset();
        end else begin
            acc = v && (mod_held.size() == 0);
            if (mod_pos >= 0 && mod_pos < W - 1) begin
                mod_pos++;
                if (acc) mod_held.push_back(d);
            end else if (mod_held.size() > 0) begin
                mod_cur = mod_held.pop_front();
                mod_pos = 0;
            end else if (acc) begin
                mod_cur = d;
                mod_pos = 0;
            end else begin
                mod_pos = -1;
            end
        end
    endtask

    // One clock cycle: drive inputs, sample mid-cycle, compare with the model, then advance.
    task automatic run(input logic en, input logic v, input logic [W-1:0] d, input int c);
        logic e_sp, e_lsp, e_sv, e_wd, e_rdy, e_busy;
        enable     = en;
        data_valid = v;
        data_in    = d;
        @(negedge clk);
        e_sv   = (mod_pos >= 0);
        e_sp   = e_sv ? mod_cur[W-1-mod_pos] : 1'b0;
        e_lsp  = e_sv ? mod_cur[mod_pos] : 1'b0;
        e_wd   = (mod_pos == W - 1);
        e_rdy  = en && (mod_held.size() == 0);
        e_busy = e_sv || (mod_held.size() > 0);
        chk("msb_pattern", 32'(m_sp), 32'(e_sp));
        chk("msb_valid", 32'(m_sv), 32'(e_sv));
        chk("msb_word_done", 32'(m_wd), 32'(e_wd));
        chk("msb_ready", 32'(m_ready), 32'(e_rdy));
        chk("msb_busy", 32'(m_busy), 32'(e_busy));
        chk("lsb_pattern", 32'(l_sp), 32'(e_lsp));
        chk("lsb_valid", 32'(l_sv), 32'(e_sv));
        h_sp[c] = m_sp; h_sv[c] = m_sv; h_wd[c] = m_wd;
        h_rdy[c] = m_ready; h_busy[c] = m_busy; h_lsp[c] = l_sp;
        @(posedge clk);
        model_step(en, v, d);
        #1;
    endtask

    function automatic logic [15:0] gather(input int from, input int n, input bit lsb);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < n; i++) r = {r[14:0], lsb ? h_lsp[from+i] : h_sp[from+i]};
        return r;
    endfunction

    initial begin
        logic [W-1:0] b1;
        rstb = 1'b0; enable = 1'b1; data_valid = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pattern", 32'(m_sp), 32'd0);
        chk("rst_valid", 32'(m_sv), 32'd0);
        chk("rst_done", 32'(m_wd), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_ready", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1 rstb = 1'b1;

        // Single word 8'hB1, MSB first.
        b1 = 8'hB1;
        tbl[0] = '{1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b1, 1'b0, 8'h00, b1[8-i], 1'b1, (i == 8), 1'b1, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            run(tbl[i].en, tbl[i].v, tbl[i].d, i);
            chk("tbl_pattern", 32'(h_sp[i]), 32'(tbl[i].sp));
            chk("tbl_valid", 32'(h_sv[i]), 32'(tbl[i].sv));
            chk("tbl_done", 32'(h_wd[i]), 32'(tbl[i].wd));
            chk("tbl_ready", 32'(h_rdy[i]), 32'(tbl[i].rdy));
            chk("tbl_busy", 32'(h_busy[i]), 32'(tbl[i].bsy));
        end

        // Back-to-back words through the holding buffer.
        for (int c = 0; c < 18; c++) run(1'b1, (c < 2), (c == 0) ? 8'hA5 : 8'h3C, c);
        chk("b2b_bits", 32'(gather(1, 16, 1'b0)), 32'h0000A53C);
        for (int c = 1; c <= 16; c++) chk("b2b_contig", 32'(h_sv[c]), 32'd1);
        for (int c = 2; c <= 8; c++) chk("b2b_ready_low", 32'(h_rdy[c]), 32'd0);
        for (int c = 1; c <= 17; c++) chk("b2b_done", 32'(h_wd[c]), 32'((c == 8) || (c == 16)));
        chk("b2b_idle_end", 32'(h_sv[17]), 32'd0);

        // Word offered only in the last-bit cycle bypasses the hold.
        for (int c = 0; c < 18; c++) run(1'b1, (c == 0) || (c == 8), (c == 0) ? 8'hFF : 8'h00, c);
        chk("byp_ready", 32'(h_rdy[8]), 32'd1);
        chk("byp_bits", 32'(gather(1, 16, 1'b0)), 32'h0000FF00);
        for (int c = 1; c <= 16; c++) chk("byp_contig", 32'(h_sv[c]), 32'd1);
        chk("byp_idle_end", 32'(h_sv[17]), 32'd0);

        // Enable dropped mid-word with a word held, then a clean restart.
        for (int c = 0; c < 15; c++)
            run((c != 4), (c < 2) || (c == 5), (c == 0) ? 8'hF0 : ((c == 1) ? 8'h0F : 8'h81), c);
        chk("en_first_bits", 32'(gather(1, 4, 1'b0)), 32'h0000000F);
        chk("en_ready_low", 32'(h_rdy[4]), 32'd0);
        chk("en_flush_valid", 32'(h_sv[5]), 32'd0);
        chk("en_flush_busy", 32'(h_busy[5]), 32'd0);
        chk("en_flush_done", 32'(h_wd[5]), 32'd0);
        chk("en_restart_ready", 32'(h_rdy[5]), 32'd1);
        chk("en_restart_bits", 32'(gather(6, 8, 1'b0)), 32'h00000081);
        chk("en_restart_done", 32'(h_wd[13]), 32'd1);
        chk("en_restart_end", 32'(h_sv[14]), 32'd0);

        // LSB-first ordering of 8'h01.
        for (int c = 0; c < 10; c++) run(1'b1, (c == 0), 8'h01, c);
        chk("lsb_bits", 32'(gather(1, 8, 1'b1)), 32'h00000080);
        chk("msb_bits_01", 32'(gather(1, 8, 1'b0)), 32'h00000001);

        // Asynchronous reset mid-stream with enable held high.
        run(1'b1, 1'b1, 8'hC3, 0);
        for (int c = 1; c < 4; c++) run(1'b1, (c == 1), 8'h5A, c);
        #3 rstb = 1'b0;
        #1;
        chk("arst_pattern", 32'(m_sp), 32'd0);
        chk("arst_valid", 32'(m_sv), 32'd0);
        chk("arst_done", 32'(m_wd), 32'd0);
        chk("arst_busy", 32'(m_busy), 32'd0);
        chk("arst_lsb_valid", 32'(l_sv), 32'd0);
        @(posedge clk);
        #1 rstb = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) run(1'b1, 1'b0, 8'h00, c);
        chk("arst_ready_after", 32'(h_rdy[0]), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++)
            run(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), W'($urandom), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_serial_pattern_gen

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Transmit-side counterpart of the team's serial pattern detection path.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial line.
- Carries a one-entry holding buffer, so back-to-back words stream with no idle gap.
- Drives the same style of serial_pattern/enable pair that the receive side samples. Used as a stimulus source and as the on-chip pattern transmitter.

Parameters:
- WIDTH, 8: bits per parallel word (legal range 2..32).
- LSB_FIRST, 0: 0 = MSB shifted first; 1 = LSB shifted first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstb  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low = synchronous flush to idle.
- data_in  input  WIDTH  parallel word to transmit.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block can accept a word this cycle. Combinational: enable && !hold_valid.
- serial_pattern  output  1  registered serial bit.
- serial_valid  output  1  registered; high in every cycle serial_pattern carries a real bit.
- word_done  output  1  registered one-cycle pulse, coincident with the last bit of each word.
- busy  output  1  registered; high while in SHIFT or while hold_valid is set.

Behaviour:
- Reset (rstb low, asynchronous):
  - state=IDLE; shift_reg, bit_cnt, hold_reg, hold_valid cleared.
  - serial_pattern=0, serial_valid=0, word_done=0, busy=0.
  - data_ready follows enable.
- Enable low at a clock edge: same clearing as reset, applied synchronously.
  - Any in-flight word and the held word are discarded. No word_done is emitted.
  - data_ready=0 while enable is low.
- Handshake:
  - A word is accepted when data_valid && data_ready at a rising edge.
  - data_in must be held stable only in the accept cycle.
- States:
  - IDLE: no bit on the line; hold is always empty in IDLE (invariant).
  - SHIFT: emitting bits.
- IDLE + accept at edge N:
  - Word loads into shift_reg; bit_cnt=0; state goes to SHIFT.
  - First bit appears on serial_pattern in cycle N+1 with serial_valid=1. Latency is 1 clock.
- SHIFT:
  - Each cycle outputs one bit; bit_cnt increments, range 0..WIDTH-1.
  - Bit order: index WIDTH-1 down to 0, or 0 up to WIDTH-1 if LSB_FIRST=1.
- SHIFT + accept while hold empty:
  - If bit_cnt != WIDTH-1 (not the last bit), the word goes into hold_reg and hold_valid is set.
  - If bit_cnt == WIDTH-1 (last bit cycle), the word bypasses hold and loads straight into shift_reg.
- Last bit of a word (bit_cnt==WIDTH-1):
  - word_done=1 in that same cycle.
  - Next shifter source, in priority order:
    1. hold_reg, if hold_valid (hold_valid clears).
    2. data_in, if accepted this cycle.
    3. Otherwise, return to IDLE with serial_valid=0 next cycle.
  - In cases 1 and 2 the next word's first bit follows with no gap.
- Full buffer: hold_valid=1 forces data_ready=0, so a held word can never be overwritten.
- serial_pattern is forced to 0 whenever serial_valid=0.
- bit_cnt width is $clog2(WIDTH). It never wraps past WIDTH-1; it resets to 0 on every load.

Decomposition:
- Shared package serial_pkg holds:
  - typedef enum logic [0:0] {IDLE, SHIFT} tx_state_t.
  - Default WIDTH constant.
- Single module, no sub-module. The holding register is small enough to stay inline.

Test Plan:
- Reset: rstb low mid-stream, with enable=1 held throughout. Outputs immediately go to serial_pattern=0, serial_valid=0, word_done=0, busy=0. data_ready=1 after release, and no stale bits appear after release.
- Single word 8'hB1 accepted at cycle 0, MSB first. Cycles 1..8 give 1,0,1,1,0,0,0,1 with serial_valid=1. word_done=1 in cycle 8 only. serial_valid=0 in cycle 9.
- Back-to-back: 8'hA5 at cycle 0, 8'h3C at cycle 1. Output is 16 contiguous bits 10100101 00111100 in cycles 1..16. data_ready=0 in cycles 2..8. word_done pulses in cycles 8 and 16.
- Bypass on last bit: 8'hFF at cycle 0, 8'h00 offered only at cycle 8 (hold empty). It is accepted, and 8 zeros follow in cycles 9..16 with serial_valid=1 and no gap.
- Enable dropped at cycle 4 of word 8'hF0 with 8'h0F held. From cycle 5: serial_valid=0, busy=0, no word_done, hold discarded. After re-enable, a new word 8'h81 shifts out cleanly with 1-cycle latency.
- LSB_FIRST=1: word 8'h01 gives 1,0,0,0,0,0,0,0 in cycles 1..8.
